// File: rtl/regfile_param.sv
// regfile_param: NREG x DW register file with PC (top index), link register (NREG-2),
// busy scoreboard and NRD combinational read ports. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_param #(
  parameter int DW = 32,
  parameter int NREG = 16,
  parameter int AW = 4,
  parameter int NRD = 3,
  parameter logic [DW-1:0] PC_RESET = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              bl,
  input  logic [DW-1:0]     pc_4_in,
  input  logic              pce,
  input  logic [DW-1:0]     pc_in,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [DW-1:0]     pc_out,
  input  logic              busy_set,
  input  logic [AW-1:0]     busy_addr,
  output logic [NREG-1:0]   busy,
  output logic [NRD-1:0]    rd_busy
);
  localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] LR_IDX = AW'(NREG - 2);

  logic [DW-1:0]   regs [NREG-1];
  logic [DW-1:0]   pc_q;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic [DW-1:0]   view [NREG];
  logic            wr_ok;

  // The general write port never targets the PC slot.
  assign wr_ok = ld && (wr_addr != PC_IDX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG - 1; i++) regs[i] <= '0;
      pc_q   <= PC_RESET;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREG - 1; i++) begin
        if (bl && (AW'(i) == LR_IDX))        regs[i] <= pc_4_in;
        else if (wr_ok && (AW'(i) == wr_addr)) regs[i] <= wr_data;
      end
      if (pce) pc_q <= pc_in;
      busy_q <= busy_nxt;
    end
  end

  // Clears first, then set, so a same-index set wins.
  always_comb begin
    busy_nxt = busy_q;
    if (wr_ok) busy_nxt[wr_addr] = 1'b0;
    if (bl)    busy_nxt[LR_IDX]  = 1'b0;
    if (busy_set && (busy_addr != PC_IDX)) busy_nxt[busy_addr] = 1'b1;
    busy_nxt[NREG-1] = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < NREG - 1; i++) view[i] = regs[i];
    view[NREG-1] = pc_q;
  end

  always_comb begin
    logic [AW-1:0] a;
    a       = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*AW +: AW];
      rd_data[k*DW +: DW] = view[a];
      rd_busy[k]          = busy_q[a];
`ifdef REGFILE_BYPASS_EN
      // Link write has priority over the general port for LR; PC is never forwarded.
      if (bl && (a == LR_IDX)) begin
        rd_data[k*DW +: DW] = pc_4_in;
        rd_busy[k]          = 1'b0;
      end else if (wr_ok && (a == wr_addr)) begin
        rd_data[k*DW +: DW] = wr_data;
        rd_busy[k]          = 1'b0;
      end
`endif
    end
  end

  assign pc_out = pc_q;
  assign busy   = busy_q;

endmodule
